// File: rtl/pool_pkg.sv
`default_nettype none
// ---- pool_pkg : shared types and helpers for the 2x2 max-pool sequencer ----
// ---- rev 1.0 ----
package pool_pkg;

   localparam int DATA_W = 13;

   typedef enum logic [1:0] {
      FILL0 = 2'd0,
      FILL1 = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pool_max4.sv
`default_nettype none
// ---- pool_max4 : signed maximum of four fixed-point values, two-level tree ----
// ---- rev 1.0 ----
module pool_max4
   import pool_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic signed [W-1:0] c,
   input  logic signed [W-1:0] d,
   output logic signed [W-1:0] max_out
);

   logic signed [W-1:0] max_ab;
   logic signed [W-1:0] max_cd;

   always_comb begin
      max_ab  = (a > b) ? a : b;
      max_cd  = (c > d) ? c : d;
      max_out = (max_ab > max_cd) ? max_ab : max_cd;
   end

endmodule
`default_nettype wire

// File: rtl/pool_control.sv
`default_nettype none
// ---- pool_control : 2x2 max-pool sequencer over two ping-pong row buffers ----
// ---- rev 1.0 ----
module pool_control
   import pool_pkg::*;
#(
   parameter int  INTEGER_BITS     = 9,
   parameter int  FIXED_POINT_BITS = 4,
   parameter int  ROW_WIDTH        = 30,
   parameter int  NUM_ROWS         = 30,
   localparam int W                = INTEGER_BITS + FIXED_POINT_BITS
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_pixel_valid,
   output logic           o_in_ready,
   output logic [1:0]     o_buf_wr,
   output logic           o_buf_rd,
   output logic           o_buf_rst,
   input  logic [2*W-1:0] i_buf0_data,
   input  logic [2*W-1:0] i_buf1_data,
   output logic [W-1:0]   o_pool_data,
   output logic           o_pool_valid,
   output logic           o_frame_done
);

   localparam int                  ROW_BITS  = clog2(NUM_ROWS) + 1;
   localparam logic [4:0]          COL_LAST  = 5'(ROW_WIDTH - 1);
   localparam logic [4:0]          PAIR_LAST = 5'(ROW_WIDTH / 2 - 1);
   localparam logic [4:0]          PAIR_EXIT = 5'(ROW_WIDTH / 2);
   localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(NUM_ROWS - 2);

   state_t              state;
   state_t              state_nxt;
   logic [4:0]          col_cnt;
   logic [4:0]          col_nxt;
   logic [ROW_BITS-1:0] row_cnt;
   logic [ROW_BITS-1:0] row_nxt;
   logic                rd;
   logic                drain_exit;
   logic [1:0]          wr;
   logic                in_ready;
   logic signed [W-1:0] max_val;

   pool_max4 #(.W(W)) u_max4 (
      .a       (i_buf0_data[2*W-1:W]),
      .b       (i_buf0_data[W-1:0]),
      .c       (i_buf1_data[2*W-1:W]),
      .d       (i_buf1_data[W-1:0]),
      .max_out (max_val)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= FILL0;
         col_cnt <= '0;
         row_cnt <= '0;
      end else begin
         state   <= state_nxt;
         col_cnt <= col_nxt;
         row_cnt <= row_nxt;
      end
   end

   // DRAIN spends ROW_WIDTH/2 read cycles plus one exit cycle that resets the buffers
   always_comb begin
      state_nxt  = state;
      col_nxt    = col_cnt;
      row_nxt    = row_cnt;
      wr         = 2'b00;
      rd         = 1'b0;
      drain_exit = 1'b0;
      in_ready   = 1'b1;
      case (state)
         FILL0: begin
            if (i_pixel_valid) begin
               wr = 2'b01;
               if (col_cnt == COL_LAST) begin
                  col_nxt   = '0;
                  state_nxt = FILL1;
               end else begin
                  col_nxt = col_cnt + 5'd1;
               end
            end
         end
         FILL1: begin
            if (i_pixel_valid) begin
               wr = 2'b10;
               if (col_cnt == COL_LAST) begin
                  col_nxt   = '0;
                  state_nxt = DRAIN;
               end else begin
                  col_nxt = col_cnt + 5'd1;
               end
            end
         end
         DRAIN: begin
            in_ready = 1'b0;
            if (col_cnt == PAIR_EXIT) begin
               drain_exit = 1'b1;
               col_nxt    = '0;
               state_nxt  = FILL0;
               row_nxt    = (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_BITS'(2);
            end else begin
               rd      = 1'b1;
               col_nxt = col_cnt + 5'd1;
            end
         end
         default: begin
            state_nxt = FILL0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_pool_data  <= '0;
         o_pool_valid <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         o_pool_valid <= rd;
         o_frame_done <= rd && (col_cnt == PAIR_LAST) && (row_cnt == ROW_LAST);
         if (rd) begin
            o_pool_data <= max_val;
         end
      end
   end

   assign o_in_ready = in_ready;
   assign o_buf_wr   = wr;
   assign o_buf_rd   = rd;
   assign o_buf_rst  = i_rst | drain_exit;

endmodule
`default_nettype wire

// File: tb/tb_pool_control.sv
`default_nettype none
// ---- tb_pool_control : scoreboard bench with line-buffer models for pool_control ----
// ---- rev 1.0 ----
module tb_pool_control;

   localparam int W     = 13;
   localparam int ROW   = 30;
   localparam int HALF  = 15;
   localparam int BANDS = 15;

   logic           clk = 1'b0;
   logic           rst;
   logic           pv;
   logic           in_ready;
   logic [1:0]     buf_wr;
   logic           buf_rd;
   logic           buf_rst;
   logic [2*W-1:0] b0_data;
   logic [2*W-1:0] b1_data;
   logic [W-1:0]   pool_data;
   logic           pool_valid;
   logic           frame_done;

   always #5 clk = ~clk;

   pool_control #(
      .INTEGER_BITS(9), .FIXED_POINT_BITS(4), .ROW_WIDTH(ROW), .NUM_ROWS(30)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_pixel_valid(pv), .o_in_ready(in_ready),
      .o_buf_wr(buf_wr), .o_buf_rd(buf_rd), .o_buf_rst(buf_rst),
      .i_buf0_data(b0_data), .i_buf1_data(b1_data),
      .o_pool_data(pool_data), .o_pool_valid(pool_valid), .o_frame_done(frame_done)
   );

   // line-buffer models: write pointer per buffer, shared pair read pointer
   logic [W-1:0] pix;
   logic [W-1:0] mem0 [32];
   logic [W-1:0] mem1 [32];
   logic [4:0]   wp0, wp1, rp;

   always @(posedge clk) begin
      if (buf_rst) begin
         wp0 <= '0;
         wp1 <= '0;
         rp  <= '0;
      end else begin
         if (buf_wr[0]) begin mem0[wp0] <= pix; wp0 <= wp0 + 5'd1; end
         if (buf_wr[1]) begin mem1[wp1] <= pix; wp1 <= wp1 + 5'd1; end
         if (buf_rd) rp <= rp + 5'd2;
      end
   end
   assign b0_data = {mem0[rp], mem0[rp + 5'd1]};
   assign b1_data = {mem1[rp], mem1[rp + 5'd1]};

   typedef struct {
      logic [W-1:0] data;
      logic         fd;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int failures = 0;
   int pulse_cnt = 0;
   int frames_seen = 0;
   int band_idx = 0;
   logic prev_rd = 1'b0;
   logic signed [W-1:0] r0 [ROW];
   logic signed [W-1:0] r1 [ROW];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic signed [W-1:0] max4m(input logic signed [W-1:0] a, b, c, d);
      logic signed [W-1:0] m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // monitor: every pooled pixel is popped from the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0) begin
         chk("wr_onehot", {31'd0, buf_wr == 2'b11}, 32'd0);
         if (!in_ready && pv) chk("drain_no_wr", {30'd0, buf_wr}, 32'd0);
         if (pool_valid) begin
            chk("latency", {31'd0, prev_rd}, 32'd1);
            if (exp_q.size() == 0) begin
               chk("unexpected_pool", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("pool_data", {19'd0, pool_data}, {19'd0, e.data});
               chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
            end
            pulse_cnt++;
         end else begin
            chk("done_without_valid", {31'd0, frame_done}, 32'd0);
         end
         if (frame_done) begin
            chk("frame_pulses", pulse_cnt, 225);
            pulse_cnt = 0;
            frames_seen++;
         end
      end
      prev_rd <= buf_rd;
   end

   task automatic send_pix(input logic [W-1:0] v, input bit gaps);
      int t;
      if (gaps && $urandom_range(0, 3) == 0) begin
         @(negedge clk);
         pv = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);
      pv  = 1'b1;
      pix = v;
      t   = 0;
      while (in_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
   endtask

   task automatic send_band(input bit gaps);
      exp_t e;
      for (int p = 0; p < HALF; p++) begin
         e.data = max4m(r0[2*p], r0[2*p+1], r1[2*p], r1[2*p+1]);
         e.fd   = (band_idx == BANDS - 1) && (p == HALF - 1);
         exp_q.push_back(e);
      end
      band_idx = (band_idx + 1) % BANDS;
      for (int c = 0; c < ROW; c++) send_pix(r0[c], gaps);
      for (int c = 0; c < ROW; c++) send_pix(r1[c], gaps);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      @(negedge clk);
      pv = 1'b0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("drain_timeout", 32'd1, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic idle_reset();
      @(negedge clk);
      rst = 1'b1;
      pv  = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      band_idx    = 0;
      pulse_cnt   = 0;
      frames_seen = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      pv  = 1'b0;
      pix = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_buf_wr", {30'd0, buf_wr}, 32'd0);
      chk("rst_buf_rd", {31'd0, buf_rd}, 32'd0);
      chk("rst_buf_rst", {31'd0, buf_rst}, 32'd1);
      chk("rst_pool_valid", {31'd0, pool_valid}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst_pool_data", {19'd0, pool_data}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // ramp band: outputs 101, 103, ... 129
      for (int c = 0; c < ROW; c++) begin
         r0[c] = W'(c);
         r1[c] = W'(100 + c);
      end
      send_band(1'b0);

      // negative band; its first pixel waits with valid high through the previous drain
      for (int c = 0; c < ROW; c++) begin
         r0[c] = W'(-5 * c - 7);
         r1[c] = W'(-11 * c - 1);
      end
      r0[0] = W'(-5);
      r0[1] = W'(-3);
      r1[0] = W'(-7);
      r1[1] = W'(-100);
      send_band(1'b0);
      wait_drain();

      // abort in the 7th drain cycle
      for (int c = 0; c < ROW; c++) begin
         r0[c] = W'(7 * c - 100);
         r1[c] = W'(50 - 3 * c);
      end
      send_band(1'b0);
      @(negedge clk);
      pv = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_in_drain", {31'd0, buf_rd}, 32'd1);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_pool_valid", {31'd0, pool_valid}, 32'd0);
      chk("abort_buf_rst", {31'd0, buf_rst}, 32'd1);
      exp_q.delete();
      band_idx  = 0;
      pulse_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < ROW; c++) begin
         r0[c] = W'(40 - 3 * c);
         r1[c] = W'(2 * c - 20);
      end
      send_band(1'b0);
      wait_drain();

      // two back-to-back frames: random gaps, then none
      idle_reset();
      for (int f = 0; f < 2; f++) begin
         for (int b = 0; b < BANDS; b++) begin
            for (int c = 0; c < ROW; c++) begin
               r0[c] = W'($urandom_range(0, 8191));
               r1[c] = W'($urandom_range(0, 8191));
            end
            send_band(f == 0);
         end
      end
      wait_drain();
      chk("frames_seen", frames_seen, 2);
      chk("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
